// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-index width and the hard-wired zero register index.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    // x0 always reads zero, so a load targeting it never creates a hazard.
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic {
        RUN      = ST_RUN,
        MEM_WAIT = ST_MEM_WAIT
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count events, stick at all-ones, and drop the event of a clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing for the IF/ID and ID/EX registers: load-use bubbles,
// taken-branch flushes and data-memory wait freezes, plus stall/flush
// performance counters. Outputs are combinational from state and inputs.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_hold,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output state_t           fsm_state
);

    state_t state;
    state_t state_next;
    logic   pend_redirect;
    logic   pend_next;
    logic   load_use;

    // The ID instruction needs a value the load in EX has not produced yet.
    always_comb begin
        load_use = mem_read_ex && (rd_ex != REG_W'(X0)) &&
                   ((use_rs1_id && (rd_ex == rs1_id)) ||
                    (use_rs2_id && (rd_ex == rs2_id)));
    end

    // State and deferred-redirect flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pend_redirect <= 1'b0;
        end else begin
            state         <= state_next;
            pend_redirect <= pend_next;
        end
    end

    // Next state and hazard outputs; freeze > redirect > load-use bubble.
    always_comb begin
        state_next  = state;
        pend_next   = pend_redirect;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_hold   = 1'b0;
        pc_redirect = 1'b0;

        case (state)
            RUN: begin
                if (dmem_busy) begin
                    // A branch resolved while frozen is remembered, not taken.
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_hold  = 1'b1;
                    pend_next  = pend_redirect | branch_taken_ex;
                    state_next = MEM_WAIT;
                end else if (branch_taken_ex) begin
                    // Wrong-path instruction in ID makes any load-use moot.
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_hold  = 1'b1;
                    pend_next  = pend_redirect | branch_taken_ex;
                end else begin
                    state_next = RUN;
                    pend_next  = 1'b0;
                    if (pend_redirect) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                state_next = RUN;
                pend_next  = 1'b0;
            end
        endcase
    end

    // Debug view of the FSM state.
    always_comb begin
        fsm_state = state;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .clr   (cnt_clr),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_redirect),
        .clr   (cnt_clr),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic use_rs1_id = 0, use_rs2_id = 0, mem_read_ex = 0;
    logic branch_taken_ex = 0, dmem_busy = 0, cnt_clr = 0;
    logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, pc_redirect;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    state_t fsm_state;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .branch_taken_ex(branch_taken_ex), .dmem_busy(dmem_busy),
        .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .idex_hold(idex_hold), .pc_redirect(pc_redirect),
        .stall_cycles(stall_cycles), .flush_events(flush_events),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];
    bit m_waiting;   // memory wait in progress
    bit m_pend;      // redirect owed once memory releases
    int m_stall;
    int m_flush;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0;
        m_pend    = 0;
        m_stall   = 0;
        m_flush   = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit busy, input bit br, input bit ld, input int rd,
                         input int r1, input int r2, input bit u1, input bit u2,
                         input bit clr);
        dmem_busy       = busy;
        branch_taken_ex = br;
        mem_read_ex     = ld;
        rd_ex           = 5'(rd);
        rs1_id          = 5'(r1);
        rs2_id          = 5'(r2);
        use_rs1_id      = u1;
        use_rs2_id      = u2;
        cnt_clr         = clr;
    endtask

    task automatic quiet();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check this cycle's outputs, clock it, then check registered results.
    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic do_cycle(input string tag);
        bit lu;
        bit redirect_due;
        logic [5:0] exp;
        logic [5:0] got;
        lu = mem_read_ex && (rd_ex != 0) &&
             ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
        redirect_due = m_waiting ? m_pend : branch_taken_ex;
        // {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, pc_redirect}
        if (dmem_busy)         exp = 6'b00_0010;
        else if (redirect_due) exp = 6'b11_1101;
        else if (lu)           exp = 6'b00_0100;
        else                   exp = 6'b11_0000;
        exp_q.push_back(exp);
        #3;
        got = {pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, pc_redirect};
        check({tag, ".outs"}, 32'(got), 32'(exp_q.pop_front()));
        check({tag, ".inv_flush_hold"}, 32'(idex_flush & idex_hold), 32'd0);
        check({tag, ".inv_redirect"},
              32'(pc_redirect & ~(ifid_flush & idex_flush)), 32'd0);

        if (dmem_busy) begin
            m_pend    = m_pend | branch_taken_ex;
            m_waiting = 1;
        end else begin
            m_pend    = 0;
            m_waiting = 0;
        end
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!exp[5])                  m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            if (exp[0])                   m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        end

        @(posedge clk);
        #1;
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        check({tag, ".flush_events"}, 32'(flush_events), 32'(m_flush));
        check({tag, ".state"}, 32'(fsm_state), 32'(m_waiting));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        quiet();
        #12;
        check("reset.outs",
              32'({pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, pc_redirect}),
              32'(6'b11_0000));
        check("reset.stall", 32'(stall_cycles), 32'd0);
        check("reset.flush", 32'(flush_events), 32'd0);
        check("reset.state", 32'(fsm_state), 32'(ST_RUN));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs1: one bubble, one stall cycle.
        drive(0, 0, 1, 5, 5, 0, 1, 0, 0);
        do_cycle("load_use");
        check("load_use.stall_is_1", 32'(stall_cycles), 32'd1);
        quiet();
        do_cycle("after_bubble");

        // x0 destination and unused rs2 match: no stall.
        drive(0, 0, 1, 0, 0, 0, 1, 1, 0);
        do_cycle("x0_dest");
        drive(0, 0, 1, 7, 1, 7, 1, 0, 0);
        do_cycle("rs2_unused");
        check("no_stall.stall_still_1", 32'(stall_cycles), 32'd1);

        // Taken branch beats a concurrent load-use.
        drive(0, 1, 1, 5, 5, 0, 1, 0, 0);
        do_cycle("branch_vs_lu");
        check("branch.flush_is_1", 32'(flush_events), 32'd1);
        check("branch.stall_unchanged", 32'(stall_cycles), 32'd1);

        // Clear, then 3 busy cycles with a branch in the 2nd, then release.
        quiet();
        cnt_clr = 1;
        do_cycle("clr0");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("busy1");
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("busy2");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("busy3");
        quiet();
        do_cycle("release");
        check("memwait.stall_is_3", 32'(stall_cycles), 32'd3);
        check("memwait.flush_is_1", 32'(flush_events), 32'd1);

        // Busy plus load-use: bubble appears on release.
        drive(1, 0, 1, 3, 3, 0, 1, 0, 0);
        do_cycle("busy_lu");
        drive(0, 0, 1, 3, 3, 0, 1, 0, 0);
        do_cycle("release_lu");

        // Reset in the middle of a memory wait with a pending redirect.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("pre_reset_busy");
        quiet();
        rst_n = 1'b0;
        model_reset();
        #2;
        check("midreset.outs",
              32'({pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, pc_redirect}),
              32'(6'b11_0000));
        check("midreset.stall", 32'(stall_cycles), 32'd0);
        check("midreset.state", 32'(fsm_state), 32'(ST_RUN));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_cycle("post_reset");
        check("post_reset.no_redirect", 32'(flush_events), 32'd0);

        // Saturation: 20 frozen cycles stick at all-ones.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            do_cycle("sat");
        end
        check("sat.stall_is_max", 32'(stall_cycles), 32'(SAT));
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        do_cycle("sat_clr");
        check("sat_clr.stall_is_0", 32'(stall_cycles), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle("sat_after_clr");
        check("sat_after_clr.stall_is_1", 32'(stall_cycles), 32'd1);

        // Random traffic with small register indices to provoke matches.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 24) == 0);
            do_cycle("rand");
        end

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
